// File: rtl/proc_pkg.sv
// Shared arbiter definitions: FSM state encoding and requester port indices.
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single-ported data memory with bus locking and lock-length fairness.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise the cpu port wins ties.
module mem_arbiter
  import proc_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_0,
  input  logic              lock_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              gnt_0,
  output logic              rvalid_0,
  input  logic              req_1,
  input  logic              lock_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_1,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fav_vld_q, fav_vld_d;
  logic             fav_port_q, fav_port_d;
  logic [1:0]       rvalid_q, rvalid_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic             ptr_q, ptr_d;
`endif

  logic [1:0] req_s, lock_s, we_s, gnt_s, xfer_s;
  logic       hi_s, win_s, own_s, sel_s;

  assign req_s  = {req_1, req_0};
  assign lock_s = {lock_1, lock_0};
  assign we_s   = {we_1, we_0};

  // A pending fairness hand-over outranks the normal tie-break.
`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign hi_s = fav_vld_q ? fav_port_q : ptr_q;
`else
  assign hi_s = fav_vld_q ? fav_port_q : PORT_CPU;
`endif
  assign win_s = req_s[hi_s] ? hi_s : other_port(hi_s);
  assign own_s = (state_q == OWN1) ? PORT_LOADER : PORT_CPU;

  // Next-state, lock counting and grant selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fav_vld_d  = fav_vld_q;
    fav_port_d = fav_port_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ptr_d      = ptr_q;
`endif
    gnt_s      = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_s) begin
          gnt_s[win_s] = 1'b1;
          fav_vld_d    = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          ptr_d        = other_port(win_s);
`endif
          if (lock_s[win_s]) begin
            if ((MAX_LOCK == 1) && req_s[other_port(win_s)]) begin
              fav_vld_d  = 1'b1;
              fav_port_d = other_port(win_s);
            end else begin
              state_d = (win_s == PORT_LOADER) ? OWN1 : OWN0;
              cnt_d   = CNT_ONE;
            end
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      OWN0, OWN1: begin
        gnt_s[own_s] = 1'b1;
        if (!req_s[own_s] || !lock_s[own_s]) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          // Owner has used its full lock budget while the other side waits.
          if ((cnt_d == CNT_MAX) && req_s[other_port(own_s)]) begin
            state_d    = IDLE;
            cnt_d      = CNT_ZERO;
            fav_vld_d  = 1'b1;
            fav_port_d = other_port(own_s);
          end else begin
            state_d = state_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign xfer_s    = gnt_s & req_s;
  assign sel_s     = gnt_s[PORT_LOADER];
  assign rvalid_d  = xfer_s & ~we_s;
  assign gnt_0     = gnt_s[PORT_CPU];
  assign gnt_1     = gnt_s[PORT_LOADER];
  assign mem_en    = |xfer_s;
  assign mem_we    = |(xfer_s & we_s);
  assign mem_addr  = mem_en ? (sel_s ? addr_1 : addr_0) : {ADDR_W{1'b0}};
  assign mem_wdata = mem_en ? (sel_s ? wdata_1 : wdata_0) : {DATA_W{1'b0}};
  assign rdata     = mem_rdata;
  assign rvalid_0  = rvalid_q[PORT_CPU];
  assign rvalid_1  = rvalid_q[PORT_LOADER];

  // State registers; reset drops ownership and any pending read response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_ZERO;
      fav_vld_q  <= 1'b0;
      fav_port_q <= 1'b0;
      rvalid_q   <= 2'b00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fav_vld_q  <= fav_vld_d;
      fav_port_q <= fav_port_d;
      rvalid_q   <= rvalid_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural reference model plus directed literal checks.
module tb_mem_arbiter;

  localparam int MAXL = 16;

  logic        clock, reset;
  logic [1:0]  req, lock, we;
  logic [9:0]  addr [2];
  logic [31:0] wdata [2];
  logic        gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;

  int n_checks = 0;
  int n_err    = 0;

  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_LOCK(MAXL)) dut (
    .clock(clock), .reset(reset),
    .req_0(req[0]), .lock_0(lock[0]), .we_0(we[0]), .addr_0(addr[0]), .wdata_0(wdata[0]),
    .gnt_0(gnt_0), .rvalid_0(rvalid_0),
    .req_1(req[1]), .lock_1(lock[1]), .we_1(we[1]), .addr_1(addr[1]), .wdata_1(wdata[1]),
    .gnt_1(gnt_1), .rvalid_1(rvalid_1),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Memory environment: one-cycle read latency.
  logic [31:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[5] = 32'hDEAD_BEEF;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clock);
      if (mem_en) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        else mem_rdata <= mem[mem_addr];
      end
    end
  end

  // Reference model: owner (-1 none), grants held, favoured port, tie pointer.
  int          m_own, m_cnt, m_fav, m_ptr;
  logic [1:0]  m_rv;
  logic [31:0] m_rd;
  logic [31:0] ref_mem [1024];

  function automatic int pick();
    int pref;
    if (m_own >= 0) return m_own;
    if (m_fav >= 0) pref = m_fav;
    else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pref = m_ptr;
`else
      pref = 0;
`endif
    end
    if (req[pref] === 1'b1) return pref;
    if (req[1-pref] === 1'b1) return 1 - pref;
    return -1;
  endfunction

  initial begin
    int  g;
    bit  done;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
    ref_mem[5] = 32'hDEAD_BEEF;
    m_own = -1; m_cnt = 0; m_fav = -1; m_ptr = 0; m_rv = 2'b00; m_rd = 32'h0;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_own = -1; m_cnt = 0; m_fav = -1; m_ptr = 0; m_rv = 2'b00;
      end else begin
        g    = pick();
        done = (g >= 0) && (req[g] === 1'b1);
        m_rv = 2'b00;
        if (done) begin
          if (we[g]) ref_mem[addr[g]] = wdata[g];
          else begin m_rv[g] = 1'b1; m_rd = ref_mem[addr[g]]; end
        end
        if (m_own < 0) begin
          if (done) begin
            m_ptr = 1 - g;
            m_fav = -1;
            if (lock[g]) begin
              if (MAXL == 1 && req[1-g]) m_fav = 1 - g;
              else begin m_own = g; m_cnt = 1; end
            end
          end
        end else if (!req[m_own] || !lock[m_own]) begin
          m_own = -1; m_cnt = 0;
        end else begin
          m_cnt = (m_cnt + 1 > MAXL) ? MAXL : m_cnt + 1;
          if (m_cnt == MAXL && req[1-m_own]) begin
            m_fav = 1 - m_own; m_own = -1; m_cnt = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    int g;
    bit x;
    g = pick();
    x = (g >= 0) && (req[g] === 1'b1);
    chk("gnt_0", 32'(gnt_0), 32'(g == 0));
    chk("gnt_1", 32'(gnt_1), 32'(g == 1));
    chk("gnt_excl", 32'(gnt_0 & gnt_1), 32'h0);
    chk("mem_en", 32'(mem_en), 32'(x));
    if (x) begin
      chk("mem_we", 32'(mem_we), 32'(we[g]));
      chk("mem_addr", 32'(mem_addr), 32'(addr[g]));
      if (we[g]) chk("mem_wdata", mem_wdata, wdata[g]);
    end else begin
      chk("mem_we_idle", 32'(mem_we), 32'h0);
    end
    chk("rvalid_0", 32'(rvalid_0), 32'(m_rv[0]));
    chk("rvalid_1", 32'(rvalid_1), 32'(m_rv[1]));
    if (m_rv != 2'b00) chk("rdata", rdata, m_rd);
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_port(input int p, input logic r, input logic l, input logic w,
                          input logic [9:0] a, input logic [31:0] d);
    req[p] = r; lock[p] = l; we[p] = w; addr[p] = a; wdata[p] = d;
  endtask

  initial begin
    int n1, n1_at0, first_after;
    bit seen0, g0, g1;
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
    set_port(1, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
    tick(); tick();
    @(negedge clock);
    chk("rst_gnt", 32'({gnt_1, gnt_0}), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_rvalid", 32'({rvalid_1, rvalid_0}), 32'h0);
    tick(); reset = 1'b0;

    // Port 0 read of address 5.
    tick(); set_port(0, 1'b1, 1'b0, 1'b0, 10'd5, 32'h0);
    @(negedge clock);
    chk("rd5_gnt_0", 32'(gnt_0), 32'h1);
    chk("rd5_mem_en", 32'(mem_en), 32'h1);
    chk("rd5_mem_we", 32'(mem_we), 32'h0);
    chk("rd5_mem_addr", 32'(mem_addr), 32'd5);
    tick(); set_port(0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
    @(negedge clock);
    chk("rd5_rvalid_0", 32'(rvalid_0), 32'h1);
    chk("rd5_rdata", rdata, 32'hDEAD_BEEF);
    chk("rd5_rvalid_1", 32'(rvalid_1), 32'h0);

    // Top-address write of all ones, then read it back.
    tick(); set_port(0, 1'b1, 1'b0, 1'b1, 10'd1023, 32'hFFFF_FFFF);
    @(negedge clock);
    chk("wr_mem_we", 32'(mem_we), 32'h1);
    chk("wr_mem_addr", 32'(mem_addr), 32'd1023);
    chk("wr_mem_wdata", mem_wdata, 32'hFFFF_FFFF);
    tick(); set_port(0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
    @(negedge clock);
    chk("wr_no_rvalid", 32'({rvalid_1, rvalid_0}), 32'h0);
    tick(); set_port(0, 1'b1, 1'b0, 1'b0, 10'd1023, 32'h0);
    tick(); set_port(0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
    @(negedge clock);
    chk("rb_rdata", rdata, 32'hFFFF_FFFF);

    // Simultaneous requests straight from reset.
    tick(); reset = 1'b1; tick(); reset = 1'b0;
    set_port(0, 1'b1, 1'b0, 1'b0, 10'd1, 32'h0);
    set_port(1, 1'b1, 1'b0, 1'b0, 10'd2, 32'h0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rr_gnt_1", 32'(gnt_1), 32'(i % 2));
      tick();
    end
    req = 2'b00;
`else
    @(negedge clock);
    chk("tie_gnt_0", 32'({gnt_1, gnt_0}), 32'h1);
    tick(); req[0] = 1'b0;
    @(negedge clock);
    chk("tie_gnt_1", 32'({gnt_1, gnt_0}), 32'h2);
    tick(); req[1] = 1'b0;
`endif

    // Locked burst of 20 writes from port 1 with port 0 waiting.
    tick();
    set_port(1, 1'b1, 1'b1, 1'b1, 10'd400, 32'h0);
    n1 = 0; seen0 = 1'b0; n1_at0 = -1; first_after = 0;
    for (int c = 0; c < 80 && n1 < 20; c++) begin
      @(negedge clock);
      g0 = gnt_0; g1 = gnt_1;
      tick();
      if (g1) begin
        n1++;
        if (seen0 && first_after == 0) first_after = 1;
        addr[1] = 10'(400 + n1); wdata[1] = 32'(n1);
      end
      if (g0) begin seen0 = 1'b1; n1_at0 = n1; req[0] = 1'b0; end
      if (c == 0 && !seen0) set_port(0, 1'b1, 1'b0, 1'b0, 10'd11, 32'h0);
    end
    chk("lock_total", 32'(n1), 32'd20);
    chk("lock_grants_before_0", 32'(n1_at0), 32'd16);
    chk("lock_resume_1", 32'(first_after), 32'd1);
    set_port(1, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
    tick();

    // Owner drops request after 3 writes while port 0 waits.
    tick(); set_port(1, 1'b1, 1'b1, 1'b1, 10'd200, 32'hA0);
    @(negedge clock); chk("drop_w1", 32'(gnt_1), 32'h1);
    tick(); set_port(1, 1'b1, 1'b1, 1'b1, 10'd201, 32'hA1);
    set_port(0, 1'b1, 1'b0, 1'b0, 10'd8, 32'h0);
    @(negedge clock); chk("drop_w2", 32'({gnt_1, gnt_0}), 32'h2);
    tick(); set_port(1, 1'b1, 1'b1, 1'b1, 10'd202, 32'hA2);
    @(negedge clock); chk("drop_w3", 32'({gnt_1, gnt_0}), 32'h2);
    tick(); set_port(1, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
    @(negedge clock); chk("drop_gap", 32'({gnt_0, mem_en}), 32'h0);
    tick();
    @(negedge clock); chk("drop_gnt_0", 32'(gnt_0), 32'h1);
    tick(); req[0] = 1'b0;

    // Lock counter saturation: 18 uncontested writes, then port 0 arrives.
    tick();
    for (int k = 0; k < 18; k++) begin
      set_port(1, 1'b1, 1'b1, 1'b1, 10'(600 + k), 32'(k));
      @(negedge clock); chk("sat_gnt_1", 32'(gnt_1), 32'h1);
      tick();
    end
    set_port(0, 1'b1, 1'b0, 1'b0, 10'd9, 32'h0);
    n1 = 0; seen0 = 1'b0;
    for (int c = 0; c < 10 && !seen0; c++) begin
      @(negedge clock);
      g0 = gnt_0; g1 = gnt_1;
      tick();
      if (g1) begin n1++; addr[1] = 10'(700 + n1); end
      if (g0) begin seen0 = 1'b1; req = 2'b00; end
    end
    chk("sat_release_seen", 32'(seen0), 32'h1);
    chk("sat_extra_grants", 32'(n1), 32'd1);
    req = 2'b00; lock = 2'b00;
    tick();

    // Reset with a read in flight.
    tick(); set_port(0, 1'b1, 1'b0, 1'b0, 10'd5, 32'h0);
    @(negedge clock); chk("rst_rd_gnt_0", 32'(gnt_0), 32'h1);
    @(posedge clock); #1;
    reset = 1'b1; req[0] = 1'b0;
    @(negedge clock);
    chk("rst_rd_rvalid_0", 32'(rvalid_0), 32'h0);
    tick(); reset = 1'b0;
    set_port(0, 1'b1, 1'b0, 1'b0, 10'd3, 32'h0);
    set_port(1, 1'b1, 1'b0, 1'b0, 10'd4, 32'h0);
    @(negedge clock); chk("rst_rd_idle_gnt", 32'({gnt_1, gnt_0}), 32'h1);
    tick(); req = 2'b00;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 10, word-address width (1024-word data memory); DATA_W, default 32, data width; MAX_LOCK, default 16, maximum consecutive locked grants to one port.
REQ-002 SHALL have ports: clock  in  1  single system clock, all state on posedge; reset  in  1  asynchronous, active-high.
REQ-003 SHALL have per requester p in {0 = cpu memory-access stage, 1 = program/debug loader}: req_p in 1 request; lock_p in 1 hold bus after this grant; we_p in 1 write when high; addr_p in ADDR_W; wdata_p in DATA_W; gnt_p out 1 grant; rvalid_p out 1 read data valid; rdata out DATA_W, shared by both ports.
REQ-004 SHALL have memory-side ports: mem_en out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W, valid one cycle after a mem_en read.

Function
REQ-005 SHALL complete a transfer on each posedge where req_p && gnt_p; at most one gnt_p high per cycle.
REQ-006 SHALL drive gnt_p, mem_en, mem_we, mem_addr and mem_wdata combinationally from the current state and the granted port's req/we/addr/wdata; mem_en = OR of req_p && gnt_p.
REQ-007 SHALL raise rvalid_p for exactly one cycle, the cycle after a completed read by port p, with rdata = mem_rdata; no response for writes.
REQ-008 SHALL keep rdata = mem_rdata at all times; rdata content SHALL be defined only when some rvalid_p is high.
REQ-009 SHALL implement FSM states IDLE, OWN0, OWN1.
REQ-010 In IDLE: grant the winner among active requesters per priority (REQ-016/017); if the winner completes a transfer with lock_p high, go to OWNp and load lock counter = 1; otherwise stay IDLE.
REQ-011 In OWNp: gnt_p high, other port blocked; each completed transfer with lock_p high increments the lock counter.
REQ-012 In OWNp: return to IDLE on a completed transfer with lock_p low, or on any cycle where req_p is low.
REQ-013 In OWNp: when the lock counter reaches MAX_LOCK and the other port is requesting, force IDLE and give the other port priority for the next grant regardless of mode.
REQ-014 Lock counter SHALL saturate at MAX_LOCK and never wrap.
REQ-015 A requester SHALL hold we/addr/wdata stable while req is high without grant; the arbiter SHALL not latch them.

Configuration
REQ-016 With macro MEM_ARB_ROUND_ROBIN_EN defined: 1-bit priority pointer, reset to port 0; after each transfer completed from IDLE, the pointer points to the other port; ties go to the pointer.
REQ-017 Without MEM_ARB_ROUND_ROBIN_EN: fixed priority, port 0 (cpu) wins every tie; the pointer is absent; REQ-013 still applies.

Reset
REQ-018 On reset: state IDLE, lock counter 0, pointer 0, rvalid_0/rvalid_1 low; with all req low, all outputs low.
REQ-019 Reset asserted mid-lock or with a read in flight SHALL drop ownership and suppress the pending rvalid.

Structure
REQ-020 SHALL place state encoding (IDLE/OWN0/OWN1) and port index constants (PORT_CPU = 0, PORT_LOADER = 1) in shared package proc_pkg.
REQ-021 SHALL be a single module with no sub-modules; the priority pick is local combinational logic.

Verification
REQ-022 Both req high, same cycle, from reset, fixed mode: gnt_0 first, gnt_1 next cycle; round-robin mode: alternates 0,1,0,1 over four reads.
REQ-023 Port 0 reads addr 5 with memory[5] = 0xDEADBEEF -> mem_en=1, mem_we=0, mem_addr=5; next cycle rvalid_0=1, rdata=0xDEADBEEF, rvalid_1=0.
REQ-024 Port 1 lock=1, 20 back-to-back writes, port 0 requesting throughout, MAX_LOCK=16 -> port 1 gets 16 grants, then port 0 is granted, then port 1 resumes.
REQ-025 Port 1 in OWN1 drops req after 3 writes, port 0 requesting -> gnt_0 on the next cycle; no cycle with both gnt high.
REQ-026 Assert reset the cycle after a port 0 read is granted -> rvalid_0 stays low; state IDLE; pointer 0.
REQ-027 Write addr 1023, data 0xFFFFFFFF from port 0 -> mem_we=1, mem_addr=1023, mem_wdata=0xFFFFFFFF; no rvalid in the following cycle.
